// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/clear sequencer with a 0.1 s prescaler and an
// M:SS.T BCD counter that drives a four-digit seven-segment multiplexer.
// Optional lap-freeze display is built when STOPWATCH_CTRL_LAP_EN is defined.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       clr,
  input  logic       lap,
  output logic [3:0] hex3,
  output logic [3:0] hex2,
  output logic [3:0] hex1,
  output logic [3:0] hex0,
  output logic [3:0] dp_out,
  output logic       running,
  output logic       ovf,
  output logic       lap_active
);

  localparam int unsigned    PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [15:0]    CNT_MAX   = 16'h9599;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_OVF
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   cnt_q, cnt_d, cnt_inc;

  // bit order: {lap, clr, go}
  logic [2:0] btn_s1_q, btn_s2_q, btn_prev_q;
  logic       go_edge, clr_edge, lap_edge;

  // Two-flop synchronizers plus previous-value register for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      btn_prev_q <= '0;
    end else begin
      btn_s1_q   <= {lap, clr, go};
      btn_s2_q   <= btn_s1_q;
      btn_prev_q <= btn_s2_q;
    end
  end

  assign go_edge  = btn_s2_q[0] & ~btn_prev_q[0];
  assign clr_edge = btn_s2_q[1] & ~btn_prev_q[1];
  assign lap_edge = btn_s2_q[2] & ~btn_prev_q[2];

  // BCD increment of M:SS.T with the full carry chain resolved in one cycle
  always_comb begin
    cnt_inc = cnt_q;
    if (cnt_q[3:0] == 4'd9) begin
      cnt_inc[3:0] = 4'd0;
      if (cnt_q[7:4] == 4'd9) begin
        cnt_inc[7:4] = 4'd0;
        if (cnt_q[11:8] == 4'd5) begin
          cnt_inc[11:8]  = 4'd0;
          cnt_inc[15:12] = cnt_q[15:12] + 4'd1;
        end else begin
          cnt_inc[11:8] = cnt_q[11:8] + 4'd1;
        end
      end else begin
        cnt_inc[7:4] = cnt_q[7:4] + 4'd1;
      end
    end else begin
      cnt_inc[3:0] = cnt_q[3:0] + 4'd1;
    end
  end

  // Next-state, prescaler and count; clr overrides everything else
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    if (clr_edge) begin
      state_d = S_IDLE;
      presc_d = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (go_edge) state_d = S_RUN;
        end
        S_RUN: begin
          if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            if (cnt_q == CNT_MAX) state_d = S_OVF;
            else                  cnt_d   = cnt_inc;
          end else begin
            presc_d = presc_q + 1'b1;
          end
          // a coincident tick is applied first; overflow wins over pause
          if (go_edge && (state_d != S_OVF)) state_d = S_PAUSE;
        end
        S_PAUSE: begin
          if (go_edge) state_d = S_RUN;
        end
        S_OVF: begin
          state_d = S_OVF;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, prescaler and live count registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign running = (state_q == S_RUN);
  assign ovf     = (state_q == S_OVF);
  assign dp_out  = (state_q == S_OVF) ? 4'b0000 : 4'b0101;

`ifdef STOPWATCH_CTRL_LAP_EN
  logic        lap_active_q, lap_active_d;
  logic [15:0] frz_q, frz_d, disp_q, disp_d;

  // Lap freeze toggle and capture; display register follows the next-state values
  always_comb begin
    lap_active_d = lap_active_q;
    frz_d        = frz_q;
    if ((state_d == S_IDLE) || (state_d == S_OVF)) begin
      lap_active_d = 1'b0;
    end else if (lap_edge && ((state_q == S_RUN) || (state_q == S_PAUSE))) begin
      lap_active_d = ~lap_active_q;
      if (!lap_active_q) frz_d = cnt_q;
    end
    disp_d = lap_active_d ? frz_d : cnt_d;
  end

  // Lap and display registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lap_active_q <= 1'b0;
      frz_q        <= '0;
      disp_q       <= '0;
    end else begin
      lap_active_q <= lap_active_d;
      frz_q        <= frz_d;
      disp_q       <= disp_d;
    end
  end

  assign {hex3, hex2, hex1, hex0} = disp_q;
  assign lap_active               = lap_active_q;
`else
  logic lap_unused;

  assign lap_unused               = lap_edge;
  assign {hex3, hex2, hex1, hex0} = cnt_q;
  assign lap_active               = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with TICK_DIV = 4.
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_CTRL_LAP_EN
  localparam bit LAP = 1'b1;
`else
  localparam bit LAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, go, clr, lap;
  logic [3:0] hex3, hex2, hex1, hex0, dp_out;
  logic       running, ovf, lap_active;

  int checks = 0;
  int errors = 0;

  stopwatch_ctrl #(.TICK_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .clr        (clr),
    .lap        (lap),
    .hex3       (hex3),
    .hex2       (hex2),
    .hex1       (hex1),
    .hex0       (hex0),
    .dp_out     (dp_out),
    .running    (running),
    .ovf        (ovf),
    .lap_active (lap_active)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] digits();
    return {hex3, hex2, hex1, hex0};
  endfunction

  initial begin
    reset = 1'b1; go = 1'b0; clr = 1'b0; lap = 1'b0;
    cyc(3);
    check("rst_hex", digits(), 16'h0000);
    check("rst_dp", {12'h0, dp_out}, 16'h0005);
    check("rst_flags", {13'h0, running, ovf, lap_active}, 16'h0000);
    reset = 1'b0;
    cyc(2);
    check("idle_hold", {15'h0, running}, 16'h0000);

    // start with go held down for a long time: one edge only
    go = 1'b1;
    cyc(2);
    check("go_lat_early", {15'h0, running}, 16'h0000);
    cyc(1);
    check("go_lat_run", {15'h0, running}, 16'h0001);
    cyc(3);
    check("pre_tick", digits(), 16'h0000);
    cyc(1);
    check("first_tick", digits(), 16'h0001);
    go = 1'b0;
    cyc(36);
    check("one_sec", digits(), 16'h0010);
    check("held_go_once", {15'h0, running}, 16'h0001);

    // minute carry through every digit on one edge
    cyc(2356);
    check("at_0599", digits(), 16'h0599);
    cyc(3);
    check("still_0599", digits(), 16'h0599);
    cyc(1);
    check("carry_1000", digits(), 16'h1000);

    // pause with prescaler held at 2 (tick coincides with go sampling)
    cyc(3);
    go = 1'b1; cyc(1); go = 1'b0;
    cyc(2);
    check("pause_state", {15'h0, running}, 16'h0000);
    check("pause_cnt", digits(), 16'h1001);
    cyc(100);
    check("pause_hold", digits(), 16'h1001);
    go = 1'b1; cyc(1); go = 1'b0;
    cyc(2);
    check("resume_run", {15'h0, running}, 16'h0001);
    cyc(1);
    check("resume_1cyc", digits(), 16'h1001);
    cyc(1);
    check("resume_tick", digits(), 16'h1002);

    // go and clr in the same cycle: clr wins
    go = 1'b1; clr = 1'b1; cyc(1); go = 1'b0; clr = 1'b0;
    cyc(2);
    check("goclr_state", {15'h0, running}, 16'h0000);
    check("goclr_cnt", digits(), 16'h0000);
    check("goclr_dp", {12'h0, dp_out}, 16'h0005);
    cyc(5);
    check("goclr_idle", {15'h0, running}, 16'h0000);

    // run, lap freeze/release, then on to 3:21.4
    go = 1'b1; cyc(1); go = 1'b0;
    cyc(2);
    check("run2_start", {15'h0, running}, 16'h0001);
    cyc(92);
    check("at_0023", digits(), 16'h0023);
    lap = 1'b1; cyc(1); lap = 1'b0;
    cyc(2);
    check("lap1_flag", {15'h0, lap_active}, {15'h0, LAP});
    check("lap1_hex", digits(), 16'h0023);
    cyc(20);
    check("lap_frozen", digits(), LAP ? 16'h0023 : 16'h0028);
    check("lap_frozen_flag", {15'h0, lap_active}, {15'h0, LAP});
    lap = 1'b1; cyc(1); lap = 1'b0;
    cyc(2);
    check("lap2_flag", {15'h0, lap_active}, 16'h0000);
    check("lap2_live", digits(), 16'h0029);
    cyc(7938);
    check("at_3214", digits(), 16'h3214);

    // asynchronous reset mid-run, go held through reset release
    go = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("async_hex", digits(), 16'h0000);
    check("async_flags", {13'h0, running, ovf, lap_active}, 16'h0000);
    check("async_dp", {12'h0, dp_out}, 16'h0005);
    cyc(2);
    reset = 1'b0;
    cyc(2);
    check("held_rst_early", {15'h0, running}, 16'h0000);
    cyc(1);
    check("held_rst_edge", {15'h0, running}, 16'h0001);
    go = 1'b0;

    // overflow at 9:59.9
    cyc(23996);
    check("at_9599", digits(), 16'h9599);
    cyc(3);
    check("pre_ovf", {14'h0, running, ovf}, 16'h0002);
    cyc(1);
    check("ovf_flags", {14'h0, running, ovf}, 16'h0001);
    check("ovf_hex", digits(), 16'h9599);
    check("ovf_dp", {12'h0, dp_out}, 16'h0000);
    go = 1'b1; cyc(1); go = 1'b0;
    cyc(5);
    check("ovf_go_ign", {14'h0, running, ovf}, 16'h0001);
    check("ovf_go_hex", digits(), 16'h9599);
    clr = 1'b1; cyc(1); clr = 1'b0;
    cyc(2);
    check("ovf_clr_flags", {14'h0, running, ovf}, 16'h0000);
    check("ovf_clr_hex", digits(), 16'h0000);
    check("ovf_clr_dp", {12'h0, dp_out}, 16'h0005);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
